// File: rtl/param_up_down_counter_if.sv
// rtl/param_up_down_counter_if.sv - control/status bundle for param_up_down_counter
interface param_up_down_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              up_dn;
    logic              ld;
    logic [WIDTH-1:0]  d;
    logic              lim_ld;
    logic [WIDTH-1:0]  lim;
    logic [STEP_W-1:0] step;
    logic              clr_flags;
    logic [WIDTH-1:0]  q;
    logic              tc;
    logic              ovf;
    logic              unf;
    logic              zero;
    logic              at_max;

    modport master (
        output en, up_dn, ld, d, lim_ld, lim, step, clr_flags,
        input  q, tc, ovf, unf, zero, at_max
    );

    modport slave (
        input  en, up_dn, ld, d, lim_ld, lim, step, clr_flags,
        output q, tc, ovf, unf, zero, at_max
    );
endinterface

// File: rtl/param_up_down_counter.sv
// rtl/param_up_down_counter.sv - modulo-(L+1) up/down counter with flags; UDC_SAT_EN selects saturation
module param_up_down_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    param_up_down_counter_if.slave bus
);
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] lim_r;
    logic             tc_r;
    logic             ovf_r;
    logic             unf_r;

    logic [WIDTH:0]   lim_p1;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   s;
    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   cnt_x;
    logic             up_bnd;
    logic             dn_bnd;
    logic             count_cyc;
    logic             up_ev;
    logic             dn_ev;
    logic [WIDTH-1:0] d_clip;

    // All arithmetic is one bit wider than the counter so q+s and L+1 never truncate.
    always_comb begin
        lim_p1 = {1'b0, lim_r} + 1'b1;
        step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
        s      = (step_x < lim_p1) ? step_x : lim_p1;
        q_x    = {1'b0, q_r};
        sum    = q_x + s;
        up_bnd = (sum > {1'b0, lim_r});
        dn_bnd = (s > q_x);
        cnt_x  = q_x;
        if (!bus.up_dn) begin
            if (!up_bnd)
                cnt_x = sum;
            else begin
`ifdef UDC_SAT_EN
                cnt_x = {1'b0, lim_r};
`else
                cnt_x = sum - lim_p1;
`endif
            end
        end else begin
            if (!dn_bnd)
                cnt_x = q_x - s;
            else begin
`ifdef UDC_SAT_EN
                cnt_x = '0;
`else
                cnt_x = q_x + lim_p1 - s;
`endif
            end
        end
    end

    assign count_cyc = bus.en & ~bus.lim_ld & ~bus.ld;
    assign up_ev     = count_cyc & ~bus.up_dn & up_bnd;
    assign dn_ev     = count_cyc &  bus.up_dn & dn_bnd;
    assign d_clip    = (bus.d > lim_r) ? lim_r : bus.d;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r   <= '0;
            lim_r <= '1;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            tc_r  <= up_ev | dn_ev;
            // A boundary event in the same cycle as clr_flags keeps the flag set.
            ovf_r <= (ovf_r & ~bus.clr_flags) | up_ev;
            unf_r <= (unf_r & ~bus.clr_flags) | dn_ev;
            if (bus.lim_ld) begin
                lim_r <= bus.lim;
                if (q_r > bus.lim)
                    q_r <= bus.lim;
            end else if (bus.ld) begin
                q_r <= d_clip;
            end else if (bus.en) begin
                q_r <= cnt_x[WIDTH-1:0];
            end
        end
    end

    assign bus.q      = q_r;
    assign bus.tc     = tc_r;
    assign bus.ovf    = ovf_r;
    assign bus.unf    = unf_r;
    assign bus.zero   = (q_r == '0);
    assign bus.at_max = (q_r == lim_r);
endmodule

// File: tb/tb_param_up_down_counter.sv
// tb/tb_param_up_down_counter.sv - directed plus randomized bench for param_up_down_counter
module tb_param_up_down_counter;
    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_up_down_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();
    param_up_down_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_q, m_lim, m_tc, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: range 0..L treated as arithmetic modulo L+1.
    task automatic model(input bit r, e, u, l, input int dv, input bit ll, input int lv,
                         input int st, input bit c);
        bit eo, eu;
        int s;
        eo = 0;
        eu = 0;
        if (r) begin
            m_q = 0; m_lim = (1 << WIDTH) - 1; m_tc = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (ll) begin
                m_lim = lv;
                if (m_q > lv) m_q = lv;
            end else if (l) begin
                m_q = (dv < m_lim) ? dv : m_lim;
            end else if (e) begin
                s = (st < m_lim + 1) ? st : m_lim + 1;
                if (!u) begin
                    if (m_q + s > m_lim) begin
                        eo = 1;
`ifdef UDC_SAT_EN
                        m_q = m_lim;
`else
                        m_q = (m_q + s) % (m_lim + 1);
`endif
                    end else m_q = m_q + s;
                end else begin
                    if (s > m_q) begin
                        eu = 1;
`ifdef UDC_SAT_EN
                        m_q = 0;
`else
                        m_q = (m_q - s + m_lim + 1) % (m_lim + 1);
`endif
                    end else m_q = m_q - s;
                end
            end
            m_tc  = int'(eo | eu);
            m_ovf = (c ? 0 : m_ovf) | int'(eo);
            m_unf = (c ? 0 : m_unf) | int'(eu);
        end
    endtask

    task automatic cyc(input bit r, e, u, l, input int dv, input bit ll, input int lv,
                       input int st, input bit c);
        reset         = r;
        bus.en        = e;
        bus.up_dn     = u;
        bus.ld        = l;
        bus.d         = dv[WIDTH-1:0];
        bus.lim_ld    = ll;
        bus.lim       = lv[WIDTH-1:0];
        bus.step      = st[STEP_W-1:0];
        bus.clr_flags = c;
        model(r, e, u, l, dv, ll, lv, st, c);
        @(posedge clk);
        #1;
        chk("q", 32'(bus.q), m_q);
        chk("tc", 32'(bus.tc), m_tc);
        chk("ovf", 32'(bus.ovf), m_ovf);
        chk("unf", 32'(bus.unf), m_unf);
        chk("zero", 32'(bus.zero), int'(m_q == 0));
        chk("at_max", 32'(bus.at_max), int'(m_q == m_lim));
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 0; bus.up_dn = 0; bus.ld = 0; bus.d = '0;
        bus.lim_ld = 0; bus.lim = '0; bus.step = '0; bus.clr_flags = 0;

        // reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_zero", 32'(bus.zero), 1);
        chk("rst_at_max", 32'(bus.at_max), 0);
        cyc(0, 0, 0, 1, 255, 0, 0, 0, 0);
        chk("lim255_at_max", 32'(bus.at_max), 1);

        // L=9, count up 1..9 then wrap to 0
        cyc(0, 0, 0, 0, 0, 1, 9, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("wrap_q", 32'(bus.q), 0);
        chk("wrap_tc", 32'(bus.tc), 1);
        chk("wrap_ovf", 32'(bus.ovf), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_ovf", 32'(bus.ovf), 0);

        // down by 3 from 0, then clr colliding with a down boundary
        cyc(0, 1, 1, 0, 0, 0, 0, 3, 0);
        chk("dn_q", 32'(bus.q), 7);
        chk("dn_unf", 32'(bus.unf), 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 3, 0);
        chk("dn2_q", 32'(bus.q), 4);
        chk("dn2_tc", 32'(bus.tc), 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 5, 1);
        chk("clr_vs_set_unf", 32'(bus.unf), 1);

        // load clamps to L, lim_ld beats ld
        cyc(0, 1, 0, 1, 200, 0, 0, 1, 0);
        chk("ld_clamp_q", 32'(bus.q), 9);
        cyc(0, 1, 0, 1, 0, 1, 5, 1, 0);
        chk("limld_q", 32'(bus.q), 5);
        chk("limld_at_max", 32'(bus.at_max), 1);

`ifdef UDC_SAT_EN
        cyc(0, 0, 0, 0, 0, 1, 9, 0, 1);
        cyc(0, 0, 0, 1, 8, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 4, 0);
        chk("sat_q", 32'(bus.q), 9);
        chk("sat_tc", 32'(bus.tc), 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 4, 0);
        chk("sat_rep_tc", 32'(bus.tc), 1);
        cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 5, 0);
        chk("sat_dn_q", 32'(bus.q), 0);
        chk("sat_dn_unf", 32'(bus.unf), 1);
`endif

        // L=0 boundary
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 7, 0);
        chk("l0_tc", 32'(bus.tc), 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("l0_step0_tc", 32'(bus.tc), 0);

        // reset mid-count
        cyc(0, 0, 0, 0, 0, 1, 255, 0, 1);
        cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("midrst_q", 32'(bus.q), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("resume_q", 32'(bus.q), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r, e, u, l, ll, c;
            int dv, lv, st;
            r  = ($urandom_range(0, 59) == 0);
            ll = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 7) == 0);
            dv = $urandom_range(0, 255);
            lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255);
            st = $urandom_range(0, 15);
            cyc(r, e, u, l, dv, ll, lv, st, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_up_down_counter.md
# param_up_down_counter

Parametrised up/down counter with programmable modulus limit, variable step, count enable, and boundary flags. It is the general-purpose successor to the 4-bit load/up/down counter. It serves as the shared event/timebase counter for the lab datapaths. Range is 0..L, where L is a runtime-loadable limit register, and boundary crossings produce a terminal-count pulse and sticky flags.

## Interface
- WIDTH, 8, counter and limit width (≥2)
- STEP_W, 4, step input width (1..WIDTH)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  count enable
- up_dn  in  1  direction: 0 = count up, 1 = count down
- ld  in  1  load q from d
- d  in  WIDTH  load data
- lim_ld  in  1  load limit register L from lim
- lim  in  WIDTH  new limit value
- step  in  STEP_W  increment/decrement magnitude per enabled cycle
- clr_flags  in  1  clear ovf/unf
- q  out  WIDTH  count value (registered)
- tc  out  1  terminal-count pulse (registered)
- ovf  out  1  sticky up-boundary flag
- unf  out  1  sticky down-boundary flag
- zero  out  1  q == 0 (combinational from q)
- at_max  out  1  q == L (combinational from q, L)

## Operation
- Priority per edge: reset > lim_ld > ld > en count > hold.
- reset: q=0, L=all ones, tc=0, ovf=0, unf=0.
- lim_ld: L←lim; q←min(q, lim). ld and count are suppressed that cycle. tc=0.
- ld: q←min(d, L). Count is suppressed. tc=0.
- Effective step s = min(step, L+1). Arithmetic is done in WIDTH+1 bits; no intermediate truncation.
- step=0 with en: q holds, tc=0, no flag change.
- Up (en, up_dn=0):
  - if q+s ≤ L: q←q+s.
  - else it is a boundary event: q←q+s−(L+1) (wrap), tc=1, ovf←1.
- Down (en, up_dn=1):
  - if s ≤ q: q←q−s.
  - else it is a boundary event: q←q−s+(L+1) (wrap), tc=1, unf←1.
- tc is high for exactly the cycle following each boundary event; otherwise 0.
- clr_flags clears ovf/unf. If a boundary event occurs in the same cycle, set wins.
- L=0: range is a single value; every enabled nonzero step is a boundary event and q stays 0.

## Timing
- All outputs except zero/at_max are registered. Update latency is 1 clock from the sampling edge.
- tc, ovf/unf update on the same edge as the q value that caused them.
- zero/at_max follow q and L combinationally within the same cycle.
- Reset values: q=0, tc=0, ovf=0, unf=0, zero=1, at_max=0 (L=all ones).
- Reset asserted mid-count overrides en/ld/lim_ld on that edge. Counting resumes on the first edge after reset deasserts.

## Configuration
- Macro UDC_SAT_EN.
- Defined: boundary events saturate instead of wrapping.
  - Up: q←L.
  - Down: q←0.
  - tc and ovf/unf still assert on every enabled nonzero-step attempt that would exceed the range, including repeat attempts while already at the limit.
- Undefined: wrap-around behaviour as in Operation. All ports are identical in both builds.

## Test plan
- Reset (WIDTH=8, STEP_W=4) → q=0, zero=1, at_max=0, tc=0, ovf=unf=0; L=255 (count 255 with ld d=255 → at_max=1).
- lim_ld lim=9, then en, up_dn=0, step=1 for 10 cycles → q=1..9,0; tc=1 only with q=0; ovf=1 thereafter; clr_flags → ovf=0.
- L=9, q=0, down with step=3 → q=7, tc=1, unf=1. Next cycle → q=4, tc=0. clr_flags with a simultaneous down boundary event → unf stays 1.
- L=9, ld d=200 with en=1 → q=9, at_max=1, no count that cycle. Then lim_ld lim=5 with ld=1 → L=5, q=5, ld ignored.
- UDC_SAT_EN defined: L=9, q=8, up step=4 → q=9, tc=1, ovf=1. Repeat → q=9, tc=1. Down from q=2 step=5 → q=0, unf=1.
- Reset asserted while en=1 up counting at q=6 → next edge q=0, flags 0, L=255. After deassert, count resumes q=1.
